// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge
//   AXI3 master bridge that serves the icache and dcache through one system AXI port.
//   Cached accesses move whole lines as INCR bursts of LINE_WORDS beats. Uncached
//   accesses move a single word, with the read data landing in word 0.
//   One read FSM is shared by both clients, and dcache reads win ties. A separate write
//   FSM carries dcache writes and acks each one only after its B response.
//
// Ports
//   clk, reset            clock and synchronous active-high reset
//   icache_*              icache read request/accept, line data, pulse and error
//   dcache_*              dcache read/write request/accept, line data, pulse and error
//   ar*/r*/aw*/w*/b*      AXI3 master channels (ID_WIDTH ids, 32-bit data, 4-bit len)
//   r_state_dbg           current read FSM state
//   w_state_dbg           current write FSM state
//
// Handshakes: every AXI transfer happens on a cycle where valid and ready are both high.
// Once valid is raised it stays high, with payload stable, until that transfer cycle.
// Client *_addr_ready is a single-cycle accept: the request is captured on that edge.
// *_data_ready is a single-cycle completion pulse, and *_err is meaningful only with it.
module cache_axi_bridge #(
   parameter int LINE_WORDS = 4,
   parameter int ID_WIDTH   = 4,
   parameter int ICACHE_ID  = 0,
   parameter int DCACHE_ID  = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      icache_req,
   input  logic                      icache_uncache,
   input  logic [31:0]               icache_addr,
   output logic                      icache_addr_ready,
   output logic                      icache_data_ready,
   output logic [32*LINE_WORDS-1:0]  icache_rdata,
   output logic                      icache_err,
   input  logic                      dcache_req,
   input  logic                      dcache_wr,
   input  logic                      dcache_uncache,
   input  logic [1:0]                dcache_size,
   input  logic [3:0]                dcache_wstrb,
   input  logic [31:0]               dcache_addr,
   input  logic [32*LINE_WORDS-1:0]  dcache_wdata,
   output logic                      dcache_addr_ready,
   output logic                      dcache_data_ready,
   output logic [32*LINE_WORDS-1:0]  dcache_rdata,
   output logic                      dcache_err,
   output logic [ID_WIDTH-1:0]       arid,
   output logic [31:0]               araddr,
   output logic [3:0]                arlen,
   output logic [2:0]                arsize,
   output logic [1:0]                arburst,
   output logic [1:0]                arlock,
   output logic [3:0]                arcache,
   output logic [2:0]                arprot,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [ID_WIDTH-1:0]       rid,
   input  logic [31:0]               rdata,
   input  logic [1:0]                rresp,
   input  logic                      rlast,
   input  logic                      rvalid,
   output logic                      rready,
   output logic [ID_WIDTH-1:0]       awid,
   output logic [31:0]               awaddr,
   output logic [3:0]                awlen,
   output logic [2:0]                awsize,
   output logic [1:0]                awburst,
   output logic [1:0]                awlock,
   output logic [3:0]                awcache,
   output logic [2:0]                awprot,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [ID_WIDTH-1:0]       wid,
   output logic [31:0]               wdata,
   output logic [3:0]                wstrb,
   output logic                      wlast,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [ID_WIDTH-1:0]       bid,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic [1:0]                r_state_dbg,
   output logic [1:0]                w_state_dbg
);

   localparam int          IDXW      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [3:0]  LINE_LEN  = 4'(LINE_WORDS - 1);
   localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);

   typedef enum logic [1:0] {R_IDLE, R_AR, R_RECV, R_DONE} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP, W_DONE} w_state_t;

   r_state_t r_state, r_next;
   w_state_t w_state, w_next;

   // read side registers
   logic        r_owner_d;                // 1 = current read belongs to dcache
   logic [31:0] ar_addr_q;
   logic [3:0]  ar_len_q;
   logic [2:0]  ar_size_q;
   logic [3:0]  r_cnt;
   logic        r_err_q;
   logic [31:0] ibuf [LINE_WORDS];
   logic [31:0] dbuf [LINE_WORDS];

   // write side registers
   logic [31:0] aw_addr_q;
   logic [3:0]  aw_len_q;
   logic [2:0]  aw_size_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wbuf [LINE_WORDS];
   logic [3:0]  w_cnt;
   logic        aw_done_q;
   logic        w_done_q;
   logic        b_err_q;

   logic d_rd_go, i_rd_go, d_wr_go;
   logic dcache_rd_done, dcache_wr_done;
   logic aw_fire, w_fire, aw_ok, w_ok;
   logic unused_ids;

   assign unused_ids = ^{rid, bid};

   // A dcache read must not overtake a pending write, and a write must not start
   // while a dcache read is in flight, so that dcache sees its accesses in order.
   assign d_rd_go = !reset && (r_state == R_IDLE) && dcache_req && !dcache_wr &&
                    (w_state == W_IDLE);
   assign i_rd_go = !reset && (r_state == R_IDLE) && icache_req && !d_rd_go;
   assign d_wr_go = !reset && (w_state == W_IDLE) && dcache_req && dcache_wr &&
                    !((r_state != R_IDLE) && r_owner_d);

   assign icache_addr_ready = i_rd_go;
   assign dcache_addr_ready = d_rd_go || d_wr_go;

   // ---------------- read FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_next;
   end

   always_comb begin
      r_next            = r_state;
      arvalid           = 1'b0;
      rready            = 1'b0;
      icache_data_ready = 1'b0;
      dcache_rd_done    = 1'b0;
      case (r_state)
         R_IDLE: if (d_rd_go || i_rd_go) r_next = R_AR;
         R_AR: begin
            arvalid = 1'b1;
            if (arready) r_next = R_RECV;
         end
         R_RECV: begin
            rready = 1'b1;
            if (rvalid && rlast) r_next = R_DONE;
         end
         R_DONE: begin
            if (r_owner_d) dcache_rd_done    = 1'b1;
            else           icache_data_ready = 1'b1;
            r_next = R_IDLE;
         end
         default: r_next = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_owner_d <= 1'b0;
         ar_addr_q <= '0;
         ar_len_q  <= '0;
         ar_size_q <= '0;
         r_cnt     <= '0;
         r_err_q   <= 1'b0;
         for (int i = 0; i < LINE_WORDS; i++) begin
            ibuf[i] <= '0;
            dbuf[i] <= '0;
         end
      end else begin
         if (d_rd_go) begin
            r_owner_d <= 1'b1;
            ar_addr_q <= dcache_uncache ? dcache_addr : (dcache_addr & LINE_MASK);
            ar_len_q  <= dcache_uncache ? 4'd0 : LINE_LEN;
            ar_size_q <= dcache_uncache ? {1'b0, dcache_size} : 3'd2;
            r_cnt     <= '0;
            r_err_q   <= 1'b0;
         end else if (i_rd_go) begin
            r_owner_d <= 1'b0;
            ar_addr_q <= icache_uncache ? icache_addr : (icache_addr & LINE_MASK);
            ar_len_q  <= icache_uncache ? 4'd0 : LINE_LEN;
            ar_size_q <= 3'd2;
            r_cnt     <= '0;
            r_err_q   <= 1'b0;
         end
         if (r_state == R_RECV && rvalid) begin
            if (r_owner_d) dbuf[r_cnt[IDXW-1:0]] <= rdata;
            else           ibuf[r_cnt[IDXW-1:0]] <= rdata;
            if (rresp != 2'b00) r_err_q <= 1'b1;
            // Saturate at len: surplus beats before a late rlast rewrite the last word.
            if (r_cnt != ar_len_q) r_cnt <= r_cnt + 4'd1;
         end
      end
   end

   assign arid    = r_owner_d ? ID_WIDTH'(DCACHE_ID) : ID_WIDTH'(ICACHE_ID);
   assign araddr  = ar_addr_q;
   assign arlen   = ar_len_q;
   assign arsize  = ar_size_q;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'b0000;
   assign arprot  = 3'b000;

   // ---------------- write FSM ----------------
   assign aw_fire = awvalid && awready;
   assign w_fire  = wvalid && wready;
   assign aw_ok   = aw_done_q || aw_fire;
   assign w_ok    = w_done_q || (w_fire && wlast);

   always_ff @(posedge clk) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_next;
   end

   always_comb begin
      w_next         = w_state;
      awvalid        = 1'b0;
      wvalid         = 1'b0;
      bready         = 1'b0;
      dcache_wr_done = 1'b0;
      case (w_state)
         W_IDLE: if (d_wr_go) w_next = W_XFER;
         W_XFER: begin
            // AW and W run independently; leave once both have finished.
            awvalid = !aw_done_q;
            wvalid  = !w_done_q;
            if (aw_ok && w_ok) w_next = W_RESP;
         end
         W_RESP: begin
            bready = 1'b1;
            if (bvalid) w_next = W_DONE;
         end
         W_DONE: begin
            dcache_wr_done = 1'b1;
            w_next         = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         aw_addr_q <= '0;
         aw_len_q  <= '0;
         aw_size_q <= '0;
         wstrb_q   <= '0;
         w_cnt     <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         b_err_q   <= 1'b0;
         for (int i = 0; i < LINE_WORDS; i++) wbuf[i] <= '0;
      end else begin
         if (d_wr_go) begin
            aw_addr_q <= dcache_uncache ? dcache_addr : (dcache_addr & LINE_MASK);
            aw_len_q  <= dcache_uncache ? 4'd0 : LINE_LEN;
            aw_size_q <= dcache_uncache ? {1'b0, dcache_size} : 3'd2;
            wstrb_q   <= dcache_uncache ? dcache_wstrb : 4'hF;
            w_cnt     <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            b_err_q   <= 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) wbuf[i] <= dcache_wdata[i*32 +: 32];
         end
         if (w_state == W_XFER) begin
            if (aw_fire) aw_done_q <= 1'b1;
            if (w_fire) begin
               if (wlast) w_done_q <= 1'b1;
               else       w_cnt    <= w_cnt + 4'd1;
            end
         end
         if (w_state == W_RESP && bvalid) b_err_q <= (bresp != 2'b00);
      end
   end

   assign awid    = ID_WIDTH'(DCACHE_ID);
   assign awaddr  = aw_addr_q;
   assign awlen   = aw_len_q;
   assign awsize  = aw_size_q;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'b0000;
   assign awprot  = 3'b000;
   assign wid     = ID_WIDTH'(DCACHE_ID);
   assign wdata   = wbuf[w_cnt[IDXW-1:0]];
   assign wstrb   = wstrb_q;
   assign wlast   = (w_cnt == aw_len_q);

   // ---------------- client outputs ----------------
   for (genvar g = 0; g < LINE_WORDS; g++) begin : g_rdata
      assign icache_rdata[g*32 +: 32] = ibuf[g];
      assign dcache_rdata[g*32 +: 32] = dbuf[g];
   end

   assign icache_err        = icache_data_ready && r_err_q;
   assign dcache_data_ready = dcache_rd_done || dcache_wr_done;
   assign dcache_err        = (dcache_rd_done && r_err_q) || (dcache_wr_done && b_err_q);

   assign r_state_dbg = r_state;
   assign w_state_dbg = w_state;

endmodule
